// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, FSM state type and address-field helpers for the icache controller.
package icache_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int INDEX_WIDTH = 5;
    localparam int LINE_WIDTH = 64;
    localparam int INSTR_WIDTH = 32;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 3;
    localparam int LINES = 1 << INDEX_WIDTH;

    typedef enum logic [2:0] {IDLE, READ, MISS_REQ, MISS_WAIT, RESP} state_t;

    function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        return a[INDEX_WIDTH+2:3];
    endfunction

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:INDEX_WIDTH+3];
    endfunction

    function automatic logic [INSTR_WIDTH-1:0] pick_half(input logic [LINE_WIDTH-1:0] line, input logic hi);
        return hi ? line[LINE_WIDTH-1:INSTR_WIDTH] : line[INSTR_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/icache_tag_array.sv
// icache_tag_array: per-line tag and valid flops with combinational lookup, single write and flush.
module icache_tag_array
    import icache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_WIDTH-1:0] lookup_index,
    input  logic [TAG_WIDTH-1:0]   lookup_tag,
    output logic                   hit,
    input  logic                   write,
    input  logic [INDEX_WIDTH-1:0] write_index,
    input  logic [TAG_WIDTH-1:0]   write_tag,
    input  logic                   invalidate
);
    logic [TAG_WIDTH-1:0] tags [LINES];
    logic [LINES-1:0] valid;

    assign hit = valid[lookup_index] && tags[lookup_index] == lookup_tag;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) valid <= '0;
        else if (invalidate) valid <= '0;
        else if (write) valid[write_index] <= 1'b1;

    always_ff @(posedge clk)
        if (write) tags[write_index] <= write_tag;
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction-cache controller in front of a 1W1R line RAM.
// Defining ICACHE_PERF_EN adds perf_hits/perf_misses counter ports.
module icache_ctrl
    import icache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_req_valid,
    output logic                   fetch_req_ready,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    output logic                   fetch_rsp_valid,
    output logic [INSTR_WIDTH-1:0] fetch_rsp_data,
    input  logic                   flush,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [LINE_WIDTH-1:0]  mem_rsp_data,
    output logic                   ram_csb0,
    output logic [INDEX_WIDTH-1:0] ram_addr0,
    output logic [LINE_WIDTH-1:0]  ram_din0,
    output logic                   ram_csb1,
    output logic [INDEX_WIDTH-1:0] ram_addr1,
    input  logic [LINE_WIDTH-1:0]  ram_dout1
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]            perf_hits,
    output logic [31:0]            perf_misses
`endif
);
    state_t state;
    logic rst_done, flush_pending, hit, accept, fill;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [INSTR_WIDTH-1:0] rsp_buf;
    logic unused_bits;

    assign unused_bits = ^{fetch_addr[1:0], addr_q[1:0]};
    assign fetch_req_ready = rst_done && !flush && state == IDLE;
    assign accept = fetch_req_valid && fetch_req_ready;
    assign fill = state == MISS_WAIT && mem_rsp_valid;
    assign ram_csb1 = !(accept && hit);
    assign ram_addr1 = accept ? addr_index(fetch_addr) : '0;
    assign ram_csb0 = !fill;
    assign ram_addr0 = fill ? addr_index(addr_q) : '0;
    assign ram_din0 = fill ? mem_rsp_data : '0;
    assign mem_req_valid = state == MISS_REQ;
    assign mem_req_addr = mem_req_valid ? {addr_q[ADDR_WIDTH-1:3], 3'b000} : '0;
    assign fetch_rsp_valid = state == READ || state == RESP;
    assign fetch_rsp_data = state == READ ? pick_half(ram_dout1, addr_q[2]) :
                            state == RESP ? rsp_buf : '0;

    // A flush seen while a fill is in flight must keep that fill from validating the line.
    icache_tag_array tag_array (
        .clk(clk),
        .rst_n(rst_n),
        .lookup_index(addr_index(fetch_addr)),
        .lookup_tag(addr_tag(fetch_addr)),
        .hit(hit),
        .write(fill && !flush_pending && !flush),
        .write_index(addr_index(addr_q)),
        .write_tag(addr_tag(addr_q)),
        .invalidate(flush)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rst_done <= 1'b0;
            flush_pending <= 1'b0;
            addr_q <= '0;
            rsp_buf <= '0;
        end else begin
            rst_done <= 1'b1;
            flush_pending <= state != IDLE && (flush_pending || flush);
            case (state)
                IDLE: if (accept) begin
                    addr_q <= fetch_addr;
                    state <= hit ? READ : MISS_REQ;
                end
                READ: state <= IDLE;
                MISS_REQ: if (mem_req_ready) state <= MISS_WAIT;
                MISS_WAIT: if (mem_rsp_valid) begin
                    rsp_buf <= pick_half(mem_rsp_data, addr_q[2]);
                    state <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hits <= '0;
            perf_misses <= '0;
        end else begin
            if (accept && hit) perf_hits <= perf_hits + 32'd1;
            if (accept && !hit) perf_misses <= perf_misses + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed fetch vectors against a behavioural data RAM, plus reset corner sequences.
module tb_icache_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic fetch_req_valid = 1'b0, flush = 1'b0, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic [63:0] mem_rsp_data = '0;
    logic fetch_req_ready, fetch_rsp_valid, mem_req_valid, ram_csb0, ram_csb1;
    logic [31:0] fetch_rsp_data, mem_req_addr;
    logic [4:0] ram_addr0, ram_addr1;
    logic [63:0] ram_din0, ram_dout1;
    logic [63:0] ram [32];
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits, perf_misses;
`endif
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!ram_csb0) ram[ram_addr0] <= ram_din0;
        if (!ram_csb1) ram_dout1 <= ram[ram_addr1];
    end

    icache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready), .fetch_addr(fetch_addr),
        .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_data(fetch_rsp_data), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .ram_csb0(ram_csb0), .ram_addr0(ram_addr0), .ram_din0(ram_din0),
        .ram_csb1(ram_csb1), .ram_addr1(ram_addr1), .ram_dout1(ram_dout1)
`ifdef ICACHE_PERF_EN
        , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [63:0] line;
        bit          miss;
        logic [31:0] exp;
        int          stall;
        bit          fl;
    } vec_t;

    // One complete fetch transaction; line is what memory returns if it misses.
    task automatic fetch(input vec_t v);
        @(negedge clk);
        fetch_req_valid = 1'b1;
        fetch_addr = v.addr;
        #1;
        check("accept_ready", 64'(fetch_req_ready), 64'(1));
        check("accept_csb1", 64'(ram_csb1), 64'(v.miss));
        if (!v.miss) check("accept_addr1", 64'(ram_addr1), 64'(v.addr[7:3]));
        @(negedge clk);
        fetch_req_valid = 1'b0;
        if (v.miss) begin
            for (int s = 0; s < v.stall; s++) begin
                #1;
                check("stall_req_valid", 64'(mem_req_valid), 64'(1));
                check("stall_req_addr", 64'(mem_req_addr), 64'({v.addr[31:3], 3'b000}));
                check("stall_ready", 64'(fetch_req_ready), 64'(0));
                @(negedge clk);
            end
            mem_req_ready = 1'b1;
            #1;
            check("req_valid", 64'(mem_req_valid), 64'(1));
            check("req_addr", 64'(mem_req_addr), 64'({v.addr[31:3], 3'b000}));
            @(negedge clk);
            mem_req_ready = 1'b0;
            if (v.fl) begin
                flush = 1'b1;
                #1;
                check("flush_no_write", 64'(ram_csb0), 64'(1));
                @(negedge clk);
                flush = 1'b0;
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data = v.line;
            #1;
            check("fill_csb0", 64'(ram_csb0), 64'(0));
            check("fill_addr0", 64'(ram_addr0), 64'(v.addr[7:3]));
            check("fill_din0", ram_din0, v.line);
            check("fill_csb1", 64'(ram_csb1), 64'(1));
            @(negedge clk);
            mem_rsp_valid = 1'b0;
        end
        #1;
        check("no_mem_req", 64'(mem_req_valid), 64'(0));
        check("rsp_valid", 64'(fetch_rsp_valid), 64'(1));
        check("rsp_data", 64'(fetch_rsp_data), 64'(v.exp));
        @(negedge clk);
        #1;
        check("rsp_pulse_end", 64'(fetch_rsp_valid), 64'(0));
        check("ready_again", 64'(fetch_req_ready), 64'(1));
    endtask

    vec_t vec [11];

    initial begin
        vec[0]  = '{32'h0000_0104, 64'h1111_2222_3333_4444, 1'b1, 32'h1111_2222, 0, 1'b0};
        vec[1]  = '{32'h0000_0100, 64'h0,                   1'b0, 32'h3333_4444, 0, 1'b0};
        vec[2]  = '{32'h0000_0104, 64'h0,                   1'b0, 32'h1111_2222, 0, 1'b0};
        vec[3]  = '{32'h0000_0200, 64'hAAAA_0001_BBBB_0002, 1'b1, 32'hBBBB_0002, 0, 1'b0};
        vec[4]  = '{32'h0000_0100, 64'h1111_2222_3333_4444, 1'b1, 32'h3333_4444, 0, 1'b0};
        vec[5]  = '{32'h0000_0ABC, 64'hCAFE_BABE_DEAD_BEEF, 1'b1, 32'hCAFE_BABE, 5, 1'b0};
        vec[6]  = '{32'h0000_0AB8, 64'h0,                   1'b0, 32'hDEAD_BEEF, 0, 1'b0};
        vec[7]  = '{32'h0000_1204, 64'h5555_6666_7777_8888, 1'b1, 32'h5555_6666, 0, 1'b1};
        vec[8]  = '{32'h0000_1204, 64'h5555_6666_7777_8888, 1'b1, 32'h5555_6666, 0, 1'b0};
        vec[9]  = '{32'h0000_0AB8, 64'hCAFE_BABE_DEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 0, 1'b0};
        vec[10] = '{32'h0000_1200, 64'h0,                   1'b0, 32'h7777_8888, 0, 1'b0};

        repeat (2) @(negedge clk);
        fetch_req_valid = 1'b1;
        fetch_addr = 32'h0000_0104;
        #1;
        check("rst_csb0", 64'(ram_csb0), 64'(1));
        check("rst_csb1", 64'(ram_csb1), 64'(1));
        check("rst_ready", 64'(fetch_req_ready), 64'(0));
        check("rst_req_valid", 64'(mem_req_valid), 64'(0));
        check("rst_rsp_valid", 64'(fetch_rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(fetch_rsp_data), 64'(0));
        @(negedge clk);
        fetch_req_valid = 1'b0;
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        #1;
        check("release_ready_low", 64'(fetch_req_ready), 64'(0));
        @(negedge clk);
        #1;
        check("first_ready", 64'(fetch_req_ready), 64'(1));
        check("idle_rsp_ignored", 64'(ram_csb0), 64'(1));
        mem_rsp_valid = 1'b0;

        for (int i = 0; i < 11; i++) begin
            fetch(vec[i]);
`ifdef ICACHE_PERF_EN
            if (i == 4) begin
                check("perf_misses", 64'(perf_misses), 64'(3));
                check("perf_hits", 64'(perf_hits), 64'(2));
            end
`endif
        end

        @(negedge clk);
        fetch_req_valid = 1'b1;
        fetch_addr = 32'h0000_2000;
        @(negedge clk);
        fetch_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midmiss_rst_ready", 64'(fetch_req_ready), 64'(0));
        check("midmiss_rst_csb0", 64'(ram_csb0), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 64'h9999_9999_9999_9999;
        #1;
        check("late_rsp_csb0_a", 64'(ram_csb0), 64'(1));
        @(negedge clk);
        #1;
        check("late_rsp_csb0_b", 64'(ram_csb0), 64'(1));
        check("late_rsp_no_req", 64'(mem_req_valid), 64'(0));
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        check("late_rsp_no_resp", 64'(fetch_rsp_valid), 64'(0));
        fetch('{32'h0000_1200, 64'h5555_6666_7777_8888, 1'b1, 32'h7777_8888, 0, 1'b0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction-cache controller that sits directly upstream of `icache_data_ram` (32 × 64-bit lines, 1W1R).
- It accepts 32-bit fetch requests from the core and tracks tag/valid state in flops.
- On a hit it reads the data RAM through port 1.
- On a miss it fetches the 64-bit line from memory, writes it to the data RAM through port 0, and returns the requested instruction.

## Interface
- ADDR_WIDTH, 32, byte fetch address width
- INDEX_WIDTH, 5, line index bits; must match data-RAM ADDR_WIDTH
- LINE_WIDTH, 64, line size in bits; must match data-RAM DATA_WIDTH
- INSTR_WIDTH, 32, instruction width returned to core

Ports:
- clk  in  1  single clock; drives clk0/clk1 of the data RAM
- rst_n  in  1  asynchronous, active-low reset
- fetch_req_valid  in  1  core fetch request
- fetch_req_ready  out  1  request accepted when valid&ready
- fetch_addr  in  ADDR_WIDTH  byte address; bits[1:0] ignored
- fetch_rsp_valid  out  1  one-cycle pulse; no backpressure
- fetch_rsp_data  out  INSTR_WIDTH  instruction
- flush  in  1  invalidate all lines
- mem_req_valid  out  1  line-fill request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  line-aligned address, bits[2:0]=0
- mem_rsp_valid  in  1  fill data valid (one beat)
- mem_rsp_data  in  LINE_WIDTH  fill line
- ram_csb0  out  1  data-RAM write select, active low
- ram_addr0  out  INDEX_WIDTH  write index
- ram_din0  out  LINE_WIDTH  write data
- ram_csb1  out  1  data-RAM read select, active low
- ram_addr1  out  INDEX_WIDTH  read index
- ram_dout1  in  LINE_WIDTH  read data, valid the cycle after ram_csb1 low

## Operation
- Address split:
  - offset = addr[2:0]; addr[2] selects the half: 1 = [63:32], 0 = [31:0].
  - index = addr[7:3].
  - tag = addr[31:8] (24 bits).
- States:
  - IDLE: ready = 1 unless flush is high. Accept a request, then compare the tag combinationally against the tag array.
    - Hit: drive ram_csb1 = 0 and ram_addr1 = index; go to READ.
    - Miss: go to MISS_REQ.
  - READ: fetch_rsp_valid = 1 with the selected half of ram_dout1; go to IDLE.
  - MISS_REQ: mem_req_valid = 1 and mem_req_addr = {tag, index, 3'b0}, both held stable until mem_req_ready; then go to MISS_WAIT.
  - MISS_WAIT: wait for mem_rsp_valid. On that cycle:
    - drive ram_csb0 = 0, ram_addr0 = index, ram_din0 = mem_rsp_data;
    - write the tag and set the valid bit;
    - capture the selected half into rsp_buf;
    - go to RESP.
  - RESP: fetch_rsp_valid = 1 with rsp_buf; go to IDLE.
- Port conflicts: the controller never drives ram_csb0 and ram_csb1 low in the same cycle, so a same-address read/write collision is impossible.
- Flush:
  - Clears all valid bits in the cycle it is high; it may be asserted in any state.
  - If flush is seen during MISS_REQ or MISS_WAIT, the fill still writes the RAM and the response is still delivered, but the valid bit is not set. A sticky flush_pending flag implements this and is cleared on the return to IDLE.
- mem_rsp_valid is ignored outside MISS_WAIT.

## Timing
- Hit latency: request accepted in cycle N, fetch_rsp_valid in N+1.
- Miss latency: fetch_rsp_valid one cycle after mem_rsp_valid.
- fetch_req_ready is low in READ, MISS_REQ, MISS_WAIT and RESP. There is one outstanding request at most.
- Reset values:
  - ram_csb0 = 1, ram_csb1 = 1.
  - All other outputs 0, including fetch_req_ready.
  - State is IDLE and all valid bits are cleared.
- fetch_req_ready is gated by a rst_done flop set on the first clk edge after rst_n rises. Ready is therefore first high one cycle after reset release.
- Reset mid-miss abandons the fill. Any later mem_rsp_valid is ignored.

## Configuration
- ICACHE_PERF_EN:
  - When defined, adds output ports perf_hits [31:0] and perf_misses [31:0].
  - perf_hits increments on each accepted hit; perf_misses on each accepted miss. Both wrap modulo 2^32, reset to 0, and are unaffected by flush.
  - When undefined, these ports and counters do not exist.

## Structure
- Package icache_pkg holds:
  - width constants (TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-3);
  - the state enum (IDLE, READ, MISS_REQ, MISS_WAIT, RESP);
  - index/tag/half-select extraction functions.
- Sub-module icache_tag_array: 32 × (tag + valid) flops, with combinational lookup, single-entry write, and invalidate-all.

## Test plan
- Cold fetch 0x0000_0104 after reset:
  - Expect mem_req_addr = 0x0000_0100.
  - Return 0x1111_2222_3333_4444; expect one-cycle ram_csb0 = 0 with ram_addr0 = 0.
  - Expect fetch_rsp_data = 0x1111_2222 the next cycle.
- Fetch 0x0000_0100:
  - Expect no mem_req_valid, and ram_csb1 = 0 with ram_addr1 = 0 in the accept cycle.
  - Expect rsp 0x3333_4444 at N+1.
- Fetch 0x0000_0200 (same index, tag 2):
  - Expect a miss and line replacement.
  - A following fetch of 0x0000_0100 misses again; with ICACHE_PERF_EN, perf_misses = 3 at that point.
- Flush asserted in MISS_WAIT:
  - The response is still delivered.
  - A refetch of the same address issues mem_req_valid again.
- mem_req_ready held low 5 cycles:
  - mem_req_valid and mem_req_addr stay stable and fetch_req_ready stays 0.
  - The request completes normally afterwards.
- rst_n pulsed low in MISS_WAIT, then mem_rsp_valid arrives:
  - The response is ignored and ram_csb0 stays 1.
  - The previous address misses on its next fetch.
